run_controller_g8: RTL

Synthesizable run-control and register-dump unit for the g8 RISC-V processor.
- Sequences the core reset and detects end of program (ebreak, ecall, PC self-loop or cycle timeout).
- Freezes the core, then streams every architectural register out over a valid/ready port.
- Replaces fixed-delay, hierarchical-print run control with parametrised on-chip behaviour usable both in simulation and on FPGA.

---
 rtl/g8_sim_pkg.sv | 29 ++
 rtl/halt_detector_g8.sv | 75 +++++++
 rtl/run_controller_g8.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/g8_sim_pkg.sv
// ============================================================================
// Module  : g8_sim_pkg
// Brief   : Shared run-state encoding, halt-cause codes and SYSTEM encodings.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package g8_sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DUMP_RD = 3'd3,
        ST_DUMP_TX = 3'd4,
        ST_DONE    = 3'd5
    } run_state_t;

    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'd0;
    localparam logic [1:0] c_CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0] c_CAUSE_ECALL   = 2'd2;
    localparam logic [1:0] c_CAUSE_LOOP    = 2'd3;

    localparam logic [31:0] c_EBREAK_INSN = 32'h0010_0073;
    localparam logic [31:0] c_ECALL_INSN  = 32'h0000_0073;

endpackage

`default_nettype wire

// File: rtl/halt_detector_g8.sv
// ============================================================================
// Module  : halt_detector_g8
// Brief   : End-of-program detection: SYSTEM insns, PC self-loop, timeout.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module halt_detector_g8 #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int LOOP_THRESH    = 4,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_insn,
    input  logic [CNT_W-1:0] cycle_count,
    output logic             halt,
    output logic [1:0]       cause
);
    import g8_sim_pkg::*;

    localparam int RUN_W = $clog2(LOOP_THRESH + 1);
    localparam logic [RUN_W-1:0] c_LOOP_THRESH = RUN_W'(LOOP_THRESH);
    localparam logic [CNT_W-1:0] c_LAST_CYCLE  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [XLEN-1:0]  r_last_pc;
    logic [RUN_W-1:0] r_run_len;
    logic [RUN_W-1:0] w_run_next;
    logic             w_ebreak;
    logic             w_ecall;
    logic             w_loop;
    logic             w_timeout;

    // r_run_len == 0 means no retirement seen yet in this run.
    assign w_run_next = (r_run_len != '0 && retire_pc == r_last_pc) ? r_run_len + 1'b1
                                                                     : RUN_W'(1);

    assign w_ebreak  = en && retire_valid && (retire_insn == c_EBREAK_INSN);
    assign w_ecall   = en && retire_valid && (retire_insn == c_ECALL_INSN);
    assign w_loop    = en && retire_valid && (w_run_next >= c_LOOP_THRESH);
    // cycle_count still holds the pre-increment value during the final RUN cycle.
    assign w_timeout = en && (cycle_count >= c_LAST_CYCLE);

    always_comb begin
        halt  = w_ebreak || w_ecall || w_loop || w_timeout;
        cause = c_CAUSE_TIMEOUT;
        if (w_ebreak)
            cause = c_CAUSE_EBREAK;
        else if (w_ecall)
            cause = c_CAUSE_ECALL;
        else if (w_loop)
            cause = c_CAUSE_LOOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_pc <= '0;
            r_run_len <= '0;
        end else if (clear) begin
            r_last_pc <= '0;
            r_run_len <= '0;
        end else if (en && retire_valid) begin
            r_last_pc <= retire_pc;
            r_run_len <= w_run_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/run_controller_g8.sv
// ============================================================================
// Module  : run_controller_g8
// Brief   : Core reset sequencing, halt detection and register dump streaming.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module run_controller_g8 #(
    parameter int XLEN           = 32,
    parameter int NREGS          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int LOOP_THRESH    = 4,
    parameter int CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      retire_valid,
    input  logic [XLEN-1:0]           retire_pc,
    input  logic [31:0]               retire_insn,
    output logic                      core_rst,
    output logic                      core_stall,
    output logic [$clog2(NREGS)-1:0]  rf_rd_addr,
    input  logic [XLEN-1:0]           rf_rd_data,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [$clog2(NREGS)-1:0]  dump_idx,
    output logic [XLEN-1:0]           dump_data,
    output logic                      done,
    output logic [1:0]                halt_cause,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          retired_count
);
    import g8_sim_pkg::*;

    localparam int IDX_W = $clog2(NREGS);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  c_RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NREGS - 1);

    run_state_t        r_state;
    run_state_t        w_state_next;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_retired_count;
    logic [1:0]        r_halt_cause;
    logic [IDX_W-1:0]  r_dump_idx;
    logic [XLEN-1:0]   r_dump_data;
    logic              w_start_ok;
    logic              w_run;
    logic              w_halt;
    logic [1:0]        w_cause;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_run      = (r_state == ST_RUN);

    halt_detector_g8 #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .LOOP_THRESH    (LOOP_THRESH),
        .CNT_W          (CNT_W)
    ) u_halt_detector (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_start_ok),
        .en           (w_run),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_insn  (retire_insn),
        .cycle_count  (r_cycle_count),
        .halt         (w_halt),
        .cause        (w_cause)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        core_rst     = 1'b0;
        core_stall   = 1'b0;
        dump_valid   = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                core_rst = 1'b1;
                if (start)
                    w_state_next = ST_RESET;
            end
            ST_RESET: begin
                core_rst = 1'b1;
                if (r_rst_cnt == c_RST_LAST)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_halt)
                    w_state_next = ST_DUMP_RD;
            end
            ST_DUMP_RD: begin
                core_stall   = 1'b1;
                w_state_next = ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
                core_stall = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready)
                    w_state_next = (r_dump_idx == c_LAST_IDX) ? ST_DONE : ST_DUMP_RD;
            end
            ST_DONE: begin
                core_stall = 1'b1;
                done       = 1'b1;
                if (start)
                    w_state_next = ST_RESET;
            end
            default: begin
                core_rst     = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt       <= '0;
            r_cycle_count   <= '0;
            r_retired_count <= '0;
            r_halt_cause    <= '0;
            r_dump_idx      <= '0;
            r_dump_data     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_rst_cnt       <= '0;
                        r_cycle_count   <= '0;
                        r_retired_count <= '0;
                    end
                end
                ST_RESET: r_rst_cnt <= r_rst_cnt + 1'b1;
                ST_RUN: begin
                    if (r_cycle_count != '1)
                        r_cycle_count <= r_cycle_count + 1'b1;
                    if (retire_valid)
                        r_retired_count <= r_retired_count + 1'b1;
                    if (w_halt) begin
                        r_halt_cause <= w_cause;
                        r_dump_idx   <= '0;
                    end
                end
                ST_DUMP_RD: r_dump_data <= rf_rd_data;
                ST_DUMP_TX: begin
                    if (dump_ready && r_dump_idx != c_LAST_IDX)
                        r_dump_idx <= r_dump_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rf_rd_addr    = r_dump_idx;
    assign dump_idx      = r_dump_idx;
    assign dump_data     = r_dump_data;
    assign halt_cause    = r_halt_cause;
    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;

endmodule

`default_nettype wire
